// File: rtl/delay_ram_sequencer.sv
// Two-tap delay line sequencer sharing one single-port sample RAM: write, read tap 1, read tap 2 per strobe.
// Optional macro DELAY_SLEW_EN: effective tap delays slew one step per sample toward the request.
module delay_ram_sequencer #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12,
    parameter int MAX_DELAY = 4095
) (
    input  logic              clkMain,
    input  logic              rst,
    input  logic              sampleStrobe,
    input  logic [DATA_W-1:0] inData,
    input  logic [ADDR_W-1:0] delay1,
    input  logic [ADDR_W-1:0] delay2,
    output logic [ADDR_W-1:0] ramAddr,
    output logic              ramWe,
    output logic [DATA_W-1:0] ramWdata,
    input  logic [DATA_W-1:0] ramRdata,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic              outValid,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD1,
        RD2,
        FIN
    } state_t;

    localparam logic [ADDR_W-1:0] MAX_D    = ADDR_W'(MAX_DELAY);
    localparam logic [ADDR_W-1:0] FILL_MAX = '1;
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   fill_q, fill_d;
    logic [ADDR_W-1:0]   dly1_q, dly1_d;
    logic [ADDR_W-1:0]   dly2_q, dly2_d;
    logic [DATA_W-1:0]   hold1_q, hold1_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_we_q, ram_we_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0]   out1_q, out1_d;
    logic [DATA_W-1:0]   out2_q, out2_d;
    logic                out_valid_q, out_valid_d;
    logic                overrun_q, overrun_d;

    function automatic logic [ADDR_W-1:0] clamp_delay(input logic [ADDR_W-1:0] req);
        return (req > MAX_D) ? MAX_D : req;
    endfunction

`ifdef DELAY_SLEW_EN
    function automatic logic [ADDR_W-1:0] step_toward(input logic [ADDR_W-1:0] cur,
                                                      input logic [ADDR_W-1:0] target);
        if (cur < target) begin
            return cur + ONE;
        end else if (cur > target) begin
            return cur - ONE;
        end
        return cur;
    endfunction
`endif

    // The write data register doubles as the latched sample; ram_addr holds through FIN and IDLE.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        dly1_d      = dly1_q;
        dly2_d      = dly2_q;
        hold1_d     = hold1_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        out1_d      = out1_q;
        out2_d      = out2_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;

        if (sampleStrobe && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (sampleStrobe) begin
`ifdef DELAY_SLEW_EN
                    dly1_d = step_toward(dly1_q, clamp_delay(delay1));
                    dly2_d = step_toward(dly2_q, clamp_delay(delay2));
`else
                    dly1_d = clamp_delay(delay1);
                    dly2_d = clamp_delay(delay2);
`endif
                    ram_addr_d  = wr_ptr_q;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = inData;
                    state_d     = WR;
                end
            end
            WR: begin
                ram_addr_d = wr_ptr_q - dly1_q;
                state_d    = RD1;
            end
            RD1: begin
                ram_addr_d = wr_ptr_q - dly2_q;
                state_d    = RD2;
            end
            RD2: begin
                hold1_d = ramRdata;
                state_d = FIN;
            end
            FIN: begin
                // A tap reaching further back than the samples written since reset reads as silence.
                out1_d      = (dly1_q > fill_q) ? '0 : hold1_q;
                out2_d      = (dly2_q > fill_q) ? '0 : ramRdata;
                out_valid_d = 1'b1;
                wr_ptr_d    = wr_ptr_q + ONE;
                fill_d      = (fill_q == FILL_MAX) ? fill_q : fill_q + ONE;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clkMain) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            dly1_q      <= '0;
            dly2_q      <= '0;
            hold1_q     <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            out1_q      <= '0;
            out2_q      <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            dly1_q      <= dly1_d;
            dly2_q      <= dly2_d;
            hold1_q     <= hold1_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            out1_q      <= out1_d;
            out2_q      <= out2_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign ramAddr  = ram_addr_q;
    assign ramWe    = ram_we_q;
    assign ramWdata = ram_wdata_q;
    assign out1     = out1_q;
    assign out2     = out2_q;
    assign outValid = out_valid_q;
    assign busy     = (state_q != IDLE);
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_delay_ram_sequencer.sv
// Directed bench for delay_ram_sequencer: default-depth instance plus a MAX_DELAY=100 instance for clamping.
module tb_delay_ram_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        strobe_a, strobe_b;
    logic [15:0] data_a, data_b;
    logic [11:0] d1_a, d2_a, d1_b, d2_b;

    logic [11:0] ram_addr_a, ram_addr_b;
    logic        ram_we_a, ram_we_b;
    logic [15:0] ram_wdata_a, ram_wdata_b;
    logic [15:0] ram_rdata_a, ram_rdata_b;
    logic [15:0] out1_a, out2_a, out1_b, out2_b;
    logic        out_valid_a, out_valid_b;
    logic        busy_a, busy_b;
    logic        overrun_a, overrun_b;

    logic [15:0] mem_a [0:4095];
    logic [15:0] mem_b [0:4095];
    logic [15:0] hist  [0:8191];
    int          n;
    int          tests;
    int          fails;

    delay_ram_sequencer dut_a (
        .clkMain(clk), .rst(rst), .sampleStrobe(strobe_a), .inData(data_a),
        .delay1(d1_a), .delay2(d2_a), .ramAddr(ram_addr_a), .ramWe(ram_we_a),
        .ramWdata(ram_wdata_a), .ramRdata(ram_rdata_a), .out1(out1_a), .out2(out2_a),
        .outValid(out_valid_a), .busy(busy_a), .overrun(overrun_a)
    );

    delay_ram_sequencer #(.MAX_DELAY(100)) dut_b (
        .clkMain(clk), .rst(rst), .sampleStrobe(strobe_b), .inData(data_b),
        .delay1(d1_b), .delay2(d2_b), .ramAddr(ram_addr_b), .ramWe(ram_we_b),
        .ramWdata(ram_wdata_b), .ramRdata(ram_rdata_b), .out1(out1_b), .out2(out2_b),
        .outValid(out_valid_b), .busy(busy_b), .overrun(overrun_b)
    );

    // Synchronous-read RAMs: data appears the cycle after the address.
    always @(posedge clk) begin
        if (ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;
        ram_rdata_a <= mem_a[ram_addr_a];
        if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
        ram_rdata_b <= mem_b[ram_addr_b];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference for one accepted sample on the default instance (no clamping below 4096).
    task automatic modelStep(input logic [15:0] data, input logic [11:0] d1, input logic [11:0] d2,
                             output logic [15:0] e1, output logic [15:0] e2,
                             output logic [11:0] wp, output logic [11:0] a1, output logic [11:0] a2);
        logic [11:0] fill;
        hist[n] = data;
        fill = (n > 4095) ? 12'd4095 : 12'(n);
        wp = 12'(n);
        a1 = wp - d1;
        a2 = wp - d2;
        e1 = 16'h0;
        e2 = 16'h0;
        if (d1 <= fill) e1 = hist[n - int'(d1)];
        if (d2 <= fill) e2 = hist[n - int'(d2)];
        n++;
    endtask

    // Called at a negedge; strobes in that cycle and returns at the negedge of cycle 5.
    task automatic applyStimulus(input logic [15:0] data, input logic [11:0] d1, input logic [11:0] d2);
        logic [15:0] e1, e2;
        logic [11:0] wp, a1, a2;
        int pulses, wes;
        modelStep(data, d1, d2, e1, e2, wp, a1, a2);
        strobe_a = 1'b1; data_a = data; d1_a = d1; d2_a = d2;
        @(negedge clk);
        strobe_a = 1'b0;
        pulses = int'(out_valid_a);
        wes = int'(ram_we_a);
        checkOutput("wr_addr", ram_addr_a, wp);
        checkOutput("wr_data", ram_wdata_a, data);
        checkOutput("busy_wr", busy_a, 1);
        @(negedge clk);
        pulses += int'(out_valid_a);
        wes += int'(ram_we_a);
        checkOutput("rd1_addr", ram_addr_a, a1);
        @(negedge clk);
        pulses += int'(out_valid_a);
        wes += int'(ram_we_a);
        checkOutput("rd2_addr", ram_addr_a, a2);
        @(negedge clk);
        pulses += int'(out_valid_a);
        wes += int'(ram_we_a);
        @(negedge clk);
        checkOutput("valid_cycle5", out_valid_a, 1);
        checkOutput("busy_cycle5", busy_a, 0);
        checkOutput("early_valid", pulses, 0);
        checkOutput("we_count", wes, 1);
        checkOutput("out1", out1_a, e1);
        checkOutput("out2", out2_a, e2);
    endtask

    task automatic applyClampStimulus(input int i);
        logic [15:0] e2;
        e2 = (i <= 100) ? 16'h0 : 16'(i - 100);
        strobe_b = 1'b1; data_b = 16'(i); d1_b = 12'd0; d2_b = 12'd3000;
        @(negedge clk);
        strobe_b = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("clamp_valid", out_valid_b, 1);
        checkOutput("clamp_out1", out1_b, 16'(i));
        checkOutput("clamp_out2", out2_b, e2);
    endtask

    initial begin
        logic [15:0] e1, e2;
        logic [11:0] wp, a1, a2;
        int pulses;
        tests = 0; fails = 0; n = 0;
        rst = 1'b1;
        strobe_a = 1'b0; data_a = '0; d1_a = '0; d2_a = '0;
        strobe_b = 1'b0; data_b = '0; d1_b = '0; d2_b = '0;
        repeat (3) @(negedge clk);

        checkOutput("rst_addr", ram_addr_a, 0);
        checkOutput("rst_we", ram_we_a, 0);
        checkOutput("rst_wdata", ram_wdata_a, 0);
        checkOutput("rst_out1", out1_a, 0);
        checkOutput("rst_out2", out2_a, 0);
        checkOutput("rst_valid", out_valid_a, 0);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_overrun", overrun_a, 0);

        strobe_a = 1'b1; data_a = 16'hDEAD;
        @(negedge clk);
        checkOutput("strobe_in_rst", busy_a, 0);
        strobe_a = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 1; i <= 6; i++) begin
            applyStimulus(16'(i), 12'd0, 12'd2);
            repeat (4) @(negedge clk);
        end

        for (int i = 7; i <= 4100; i++) begin
            applyStimulus(16'(i * 3 + 5), 12'd4095, 12'(i % 37));
        end

        // Second strobe lands in RD1 and must be dropped.
        checkOutput("overrun_clear", overrun_a, 0);
        modelStep(16'hA5A5, 12'd1, 12'd3, e1, e2, wp, a1, a2);
        strobe_a = 1'b1; data_a = 16'hA5A5; d1_a = 12'd1; d2_a = 12'd3;
        @(negedge clk);
        strobe_a = 1'b0;
        pulses = int'(out_valid_a);
        @(negedge clk);
        pulses += int'(out_valid_a);
        checkOutput("overrun_pre", overrun_a, 0);
        strobe_a = 1'b1; data_a = 16'h5A5A; d1_a = 12'd0; d2_a = 12'd0;
        @(negedge clk);
        strobe_a = 1'b0;
        pulses += int'(out_valid_a);
        checkOutput("overrun_set", overrun_a, 1);
        checkOutput("ovr_rd2_addr", ram_addr_a, a2);
        @(negedge clk);
        pulses += int'(out_valid_a);
        @(negedge clk);
        checkOutput("ovr_valid", out_valid_a, 1);
        checkOutput("ovr_early_valid", pulses, 0);
        checkOutput("ovr_out1", out1_a, e1);
        checkOutput("ovr_out2", out2_a, e2);
        applyStimulus(16'h1234, 12'd5, 12'd4095);
        checkOutput("overrun_held", overrun_a, 1);

        // Reset lands in the RD1 cycle.
        strobe_a = 1'b1; data_a = 16'h7777; d1_a = 12'd0; d2_a = 12'd0;
        @(negedge clk);
        strobe_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", busy_a, 0);
        checkOutput("midrst_we", ram_we_a, 0);
        checkOutput("midrst_out1", out1_a, 0);
        checkOutput("midrst_out2", out2_a, 0);
        checkOutput("midrst_valid", out_valid_a, 0);
        checkOutput("midrst_overrun", overrun_a, 0);
        rst = 1'b0;
        n = 0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            pulses += int'(out_valid_a);
        end
        checkOutput("midrst_no_valid", pulses, 0);
        applyStimulus(16'hBEEF, 12'd0, 12'd2);
        applyStimulus(16'hCAFE, 12'd1, 12'd1);

        for (int i = 1; i <= 110; i++) begin
            applyClampStimulus(i);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
